wb_scheduler: RTL and testbench

WB_SCHEDULER -- requirements
Module: wb_scheduler

---
 rtl/wb_scheduler_pkg.sv | 14 +
 rtl/riscv_defines.v | 6 +
 rtl/wb_scheduler_arb.sv | 42 ++++
 rtl/wb_scheduler.sv | 98 +++++++++
 tb/tb_wb_scheduler.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_scheduler_pkg.sv
// Shared types for the writeback scheduler: grant encoding between arbiter and top.
`ifndef RISCV_WORD_WIDTH
`include "riscv_defines.v"
`endif

package wb_scheduler_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LSU  = 2'd2
  } gnt_e;

endpackage

// File: rtl/riscv_defines.v
// Core-wide architectural widths shared by the RISC-V datapath blocks.
`ifndef RISCV_DEFINES_V
`define RISCV_DEFINES_V
`define RISCV_WORD_WIDTH 32
`define GP_REG_COUNT 32
`endif

// File: rtl/wb_scheduler_arb.sv
// Two-requester writeback arbiter: LSU-first, with ALU guaranteed a slot after two LSU wins.
module wb_arb
  import wb_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic alu_valid,
  input  logic lsu_valid,
  output gnt_e gnt
);

  logic [1:0] lsu_streak;
  logic [1:0] lsu_streak_nxt;

  always_comb begin
    gnt = GNT_NONE;
    if (lsu_valid && !(alu_valid && lsu_streak == 2'd2)) begin
      gnt = GNT_LSU;
    end else if (alu_valid) begin
      gnt = GNT_ALU;
    end
  end

  // Streak only counts LSU wins that made a waiting ALU lose.
  always_comb begin
    lsu_streak_nxt = lsu_streak;
    if (!alu_valid || gnt == GNT_ALU) begin
      lsu_streak_nxt = 2'd0;
    end else if (gnt == GNT_LSU && lsu_streak != 2'd2) begin
      lsu_streak_nxt = lsu_streak + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsu_streak <= 2'd0;
    end else begin
      lsu_streak <= lsu_streak_nxt;
    end
  end

endmodule

// File: rtl/wb_scheduler.sv
// Register scoreboard and single-port writeback scheduler between ALU/LSU and the register file.
`ifndef RISCV_WORD_WIDTH
`include "riscv_defines.v"
`endif

module wb_scheduler
  import wb_scheduler_pkg::*;
#(
  parameter int XLEN = `RISCV_WORD_WIDTH,
  parameter int NREG = `GP_REG_COUNT,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid_i,
  input  logic [AW-1:0]   issue_rd_i,
  input  logic [AW-1:0]   issue_rs1_i,
  input  logic [AW-1:0]   issue_rs2_i,
  input  logic            issue_wr_i,
  output logic            issue_ready_o,
  input  logic            alu_valid_i,
  input  logic [AW-1:0]   alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  output logic            alu_ready_o,
  input  logic            lsu_valid_i,
  input  logic [AW-1:0]   lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  output logic            lsu_ready_o,
  output logic            rf_write_en_o,
  output logic [AW-1:0]   rf_write_addr_o,
  output logic [XLEN-1:0] rf_write_data_o,
  output logic [NREG-1:0] pending_o,
  output logic            wb_err_o
);

  // Handshakes: issue and writeback requests transfer on a rising edge where valid && ready;
  // ready never depends on same-cycle commits, and valid is not required to hold after a loss.

  gnt_e            gnt;
  logic            any_gnt;
  logic            issue_fire;
  logic [AW-1:0]   gnt_rd;
  logic [XLEN-1:0] gnt_data;
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_nxt;

  wb_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid_i),
    .lsu_valid (lsu_valid_i),
    .gnt       (gnt)
  );

  assign alu_ready_o = (gnt == GNT_ALU);
  assign lsu_ready_o = (gnt == GNT_LSU);
  assign any_gnt     = (gnt != GNT_NONE);
  assign gnt_rd      = lsu_ready_o ? lsu_rd_i   : alu_rd_i;
  assign gnt_data    = lsu_ready_o ? lsu_data_i : alu_data_i;
  assign pending_o   = pending_q;

  assign issue_ready_o = !(pending_q[issue_rs1_i] || pending_q[issue_rs2_i] ||
                           (issue_wr_i && pending_q[issue_rd_i]));
  assign issue_fire    = issue_valid_i && issue_ready_o;

  // Clear first so a same-edge issue set wins on the same bit.
  always_comb begin
    pending_nxt = pending_q;
    if (rf_write_en_o) begin
      pending_nxt[rf_write_addr_o] = 1'b0;
    end
    if (issue_fire && issue_wr_i) begin
      pending_nxt[issue_rd_i] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q       <= '0;
      rf_write_en_o   <= 1'b0;
      rf_write_addr_o <= '0;
      rf_write_data_o <= '0;
      wb_err_o        <= 1'b0;
    end else begin
      pending_q     <= pending_nxt;
      rf_write_en_o <= any_gnt && (gnt_rd != '0);
      if (any_gnt) begin
        rf_write_addr_o <= gnt_rd;
        rf_write_data_o <= gnt_data;
      end
      if (any_gnt && gnt_rd != '0 && !pending_q[gnt_rd]) begin
        wb_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_scheduler.sv
// Self-checking bench for wb_scheduler: directed scenarios then randomized traffic against a reference model.
module tb_wb_scheduler;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            issue_valid_i, issue_wr_i, issue_ready_o;
  logic [AW-1:0]   issue_rd_i, issue_rs1_i, issue_rs2_i;
  logic            alu_valid_i, alu_ready_o, lsu_valid_i, lsu_ready_o;
  logic [AW-1:0]   alu_rd_i, lsu_rd_i;
  logic [XLEN-1:0] alu_data_i, lsu_data_i;
  logic            rf_write_en_o, wb_err_o;
  logic [AW-1:0]   rf_write_addr_o;
  logic [XLEN-1:0] rf_write_data_o;
  logic [NREG-1:0] pending_o;

  wb_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_valid_i   (issue_valid_i),
    .issue_rd_i      (issue_rd_i),
    .issue_rs1_i     (issue_rs1_i),
    .issue_rs2_i     (issue_rs2_i),
    .issue_wr_i      (issue_wr_i),
    .issue_ready_o   (issue_ready_o),
    .alu_valid_i     (alu_valid_i),
    .alu_rd_i        (alu_rd_i),
    .alu_data_i      (alu_data_i),
    .alu_ready_o     (alu_ready_o),
    .lsu_valid_i     (lsu_valid_i),
    .lsu_rd_i        (lsu_rd_i),
    .lsu_data_i      (lsu_data_i),
    .lsu_ready_o     (lsu_ready_o),
    .rf_write_en_o   (rf_write_en_o),
    .rf_write_addr_o (rf_write_addr_o),
    .rf_write_data_o (rf_write_data_o),
    .pending_o       (pending_o),
    .wb_err_o        (wb_err_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_err    = 0;

  logic [NREG-1:0]    m_pend;
  logic               m_err;
  int                 m_lsu_run;
  logic [AW-1:0]      m_last_addr;
  logic [XLEN-1:0]    m_last_data;
  logic [AW+XLEN-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend      = '0;
    m_err       = 1'b0;
    m_lsu_run   = 0;
    m_last_addr = '0;
    m_last_data = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    issue_valid_i = 1'b0; issue_wr_i = 1'b0;
    issue_rd_i = '0; issue_rs1_i = '0; issue_rs2_i = '0;
    alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
    lsu_valid_i = 1'b0; lsu_rd_i = '0; lsu_data_i = '0;
  endtask

  // One cycle: drive at negedge, check registered and combinational outputs, advance model.
  task automatic step(input logic iv, input logic [AW-1:0] ird, input logic [AW-1:0] irs1,
                      input logic [AW-1:0] irs2, input logic iwr,
                      input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                      input logic lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ld);
    logic [AW+XLEN-1:0] w;
    logic               has_w, exp_rdy, e_alu, e_lsu;
    logic [AW-1:0]      g_rd;
    logic [XLEN-1:0]    g_d;
    @(negedge clk);
    issue_valid_i = iv; issue_rd_i = ird; issue_rs1_i = irs1; issue_rs2_i = irs2; issue_wr_i = iwr;
    alu_valid_i = av; alu_rd_i = ard; alu_data_i = ad;
    lsu_valid_i = lv; lsu_rd_i = lrd; lsu_data_i = ld;
    #1;
    has_w = (exp_q.size() > 0);
    if (has_w) w = exp_q.pop_front();
    else       w = {m_last_addr, m_last_data};
    check_eq("pending", pending_o, m_pend);
    check_eq("wb_err", wb_err_o, m_err);
    check_eq("wr_en", rf_write_en_o, has_w);
    check_eq("wr_addr", rf_write_addr_o, w[XLEN +: AW]);
    check_eq("wr_data", rf_write_data_o, w[XLEN-1:0]);

    exp_rdy = !(m_pend[irs1] || m_pend[irs2] || (iwr && m_pend[ird]));
    e_lsu   = lv && !(av && m_lsu_run == 2);
    e_alu   = av && !e_lsu;
    check_eq("issue_ready", issue_ready_o, exp_rdy);
    check_eq("alu_ready", alu_ready_o, e_alu);
    check_eq("lsu_ready", lsu_ready_o, e_lsu);

    if (e_alu || e_lsu) begin
      g_rd = e_lsu ? lrd : ard;
      g_d  = e_lsu ? ld  : ad;
      if (g_rd != '0 && !m_pend[g_rd]) m_err = 1'b1;
      m_last_addr = g_rd;
      m_last_data = g_d;
      if (g_rd != '0) exp_q.push_back({g_rd, g_d});
    end
    if (e_lsu && av) m_lsu_run = (m_lsu_run >= 2) ? 2 : m_lsu_run + 1;
    else             m_lsu_run = 0;
    if (has_w) m_pend[w[XLEN +: AW]] = 1'b0;
    if (iv && exp_rdy && iwr && ird != '0) m_pend[ird] = 1'b1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_pending", pending_o, '0);
    check_eq("rst_wr_en", rf_write_en_o, 1'b0);
    check_eq("rst_wr_addr", rf_write_addr_o, '0);
    check_eq("rst_wr_data", rf_write_data_o, '0);
    check_eq("rst_wb_err", wb_err_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
           AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom(),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom());
    end
  endtask

  // ---------------- stimulus ----------------
  logic exp_lsu_seq [5];

  initial begin
    drive_idle();
    model_reset();
    exp_lsu_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();

    // Issue rd=5, ALU writes it back, pending clears the cycle after commit.
    step(1'b1, AW'(5), '0, '0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    idle();
    check_eq("p5_set", pending_o[5], 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, AW'(5), 32'hDEADBEEF, 1'b0, '0, '0);
    check_eq("alu_gnt_single", alu_ready_o, 1'b1);
    idle();
    check_eq("dbf_en", rf_write_en_o, 1'b1);
    check_eq("dbf_addr", rf_write_addr_o, AW'(5));
    check_eq("dbf_data", rf_write_data_o, 32'hDEADBEEF);
    idle();
    check_eq("p5_clear", pending_o[5], 1'b0);

    // RAW hazard on x3 holds issue until the cycle after the commit.
    step(1'b1, AW'(3), '0, '0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b1, '0, AW'(3), '0, 1'b0, 1'b1, AW'(3), 32'h1234_5678, 1'b0, '0, '0);
    check_eq("raw_stall_a", issue_ready_o, 1'b0);
    step(1'b1, '0, AW'(3), '0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    check_eq("raw_stall_commit", issue_ready_o, 1'b0);
    check_eq("raw_commit_addr", rf_write_addr_o, AW'(3));
    step(1'b1, '0, AW'(3), '0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    check_eq("raw_release", issue_ready_o, 1'b1);

    // Both requesters valid: L,L,A,L,L.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, '0, '0, 1'b0, 1'b1, '0, $urandom(), 1'b1, '0, $urandom());
      check_eq($sformatf("arb_seq%0d", i), lsu_ready_o, exp_lsu_seq[i]);
    end
    idle();

    // Writeback to x0 is swallowed without an error.
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1, '0, 32'h1);
    idle();
    check_eq("x0_no_write", rf_write_en_o, 1'b0);
    check_eq("x0_no_err", wb_err_o, 1'b0);

    // Writeback to non-pending x7 flags a sticky error but still writes.
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, AW'(7), 32'hCAFE_0007, 1'b0, '0, '0);
    idle();
    check_eq("err_set", wb_err_o, 1'b1);
    check_eq("err_still_writes", rf_write_en_o, 1'b1);
    repeat (3) idle();
    check_eq("err_sticky", wb_err_o, 1'b1);

    // Reset right after a grant drops the in-flight write.
    step(1'b1, AW'(9), '0, '0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, AW'(9), 32'h0BAD_F00D, 1'b0, '0, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("mid_rst_wr_en", rf_write_en_o, 1'b0);
    check_eq("mid_rst_pending", pending_o, '0);
    check_eq("mid_rst_err", wb_err_o, 1'b0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    idle();
    check_eq("post_rst_no_write", rf_write_en_o, 1'b0);

    random_phase(300);
    do_reset();
    random_phase(300);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
